nand_gate_sequencer: RTL and testbench
======================================

# nand_gate_sequencer

Self-checking stimulus controller for the two-input `nand_gate` datapath. On a start pulse it drives `din_a`/`din_b` through all four input combinations and holds each for a programmable number of cycles. It samples the gate's `dout`, compares it against a parameterised truth table and reports a pass/fail summary. It sits between a test/control host and one `nand_gate` instance, replacing hand-written stimulus sequences with a clocked, repeatable exercise.

## Interface
- `HOLD_CYCLES`, default 1: cycles each vector is driven before sampling; legal range ≥1.
- `EXPECT`, default 4'b0111: expected `dout` per vector, indexed by `{din_a,din_b}` (bit 0 = vector 00). The default is the NAND truth table.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: begin a run; sampled only in IDLE.
- `dout` input 1: output of the gate under control.
- `din_a` output 1: gate input A, registered.
- `din_b` output 1: gate input B, registered.
- `busy` output 1: high during DRIVE and SAMPLE.
- `done` output 1: one-cycle pulse when a run ends.
- `pass` output 1: 1 if the last completed run had zero mismatches.
- `err_cnt` output 3: mismatch count of the current or last run, 0..4.
- `first_fail` output 2: vector index of the first mismatch; 0 if none.
- `vec_idx` output 2: vector currently driven.

## Operation
- FSM has four states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - `start`=1 → DRIVE.
  - Clear `vec_idx`, `err_cnt`, `first_fail`, the hold counter and `pass`.
  - Drive `{din_a,din_b}`=2'b00.
- DRIVE:
  - `{din_a,din_b}` = `vec_idx`, with `din_a` as the MSB.
  - The hold counter counts 0..HOLD_CYCLES-1, then → SAMPLE.
- SAMPLE (one cycle):
  - Compare `dout` with `EXPECT[vec_idx]`.
  - On a mismatch, increment `err_cnt`. If `err_cnt` was 0 before the increment, load `first_fail`=`vec_idx`.
  - If `vec_idx`==3 → DONE. Otherwise increment `vec_idx`, clear the hold counter and → DRIVE.
- DONE (one cycle):
  - `done`=1.
  - `pass` = (`err_cnt`==0); it holds until the next start or reset.
  - → IDLE.
- Vector order is fixed: 00, 01, 10, 11.
- `vec_idx` never wraps within a run.
- `din_a`/`din_b` keep their last value (11) after DONE and return to 00 on the next start.
- `start` in DRIVE, SAMPLE or DONE is ignored. It is neither queued nor restarts the run.
- `err_cnt` cannot exceed 4, so no saturation logic is needed.

## Timing
- Reset values (async, immediate on `rst_n` low):
  - state IDLE.
  - `din_a`=0, `din_b`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `first_fail`=0, `vec_idx`=0.
- Cycle 0: `start` is seen in IDLE.
- Cycle 1: DRIVE, vector 00 on the outputs, `busy`=1.
- Each vector occupies HOLD_CYCLES+1 cycles.
- `dout` is sampled at the rising edge that ends the SAMPLE cycle. The gate therefore has at least HOLD_CYCLES full cycles to settle.
- `done` is high in cycle 4·(HOLD_CYCLES+1)+1. With HOLD_CYCLES=1, that is cycle 9.
- `busy` falls in the same cycle `done` rises.
- `err_cnt` and `first_fail` update one cycle after the corresponding SAMPLE cycle.
- `pass` becomes valid in the DONE cycle.
- Reset asserted mid-run:
  - The run aborts and all outputs immediately take their reset values.
  - No `done` pulse occurs.
  - After release, the block stays in IDLE until a new `start`.

## Configuration
- `NAND_SEQ_STOP_ON_FAIL_EN` defined: on the first mismatch, SAMPLE → DONE directly. The result is `err_cnt`=1, `first_fail` = failing vector, `pass`=0, and the remaining vectors are not driven.
- Macro undefined: all four vectors always run, and `err_cnt` counts every mismatch.

## Test plan
- Correct NAND model, HOLD_CYCLES=1, `start` pulse at cycle 0:
  - `din` sequence 00,01,10,11 at two cycles each.
  - `done` at cycle 9.
  - `pass`=1, `err_cnt`=0, `first_fail`=0.
- `dout` stuck at 1 → `err_cnt`=1, `first_fail`=3, `pass`=0.
- AND gate substituted for the NAND, macro undefined → `err_cnt`=4, `first_fail`=0, `pass`=0, `done` at cycle 9.
- AND gate substituted for the NAND, `NAND_SEQ_STOP_ON_FAIL_EN` defined → `done` at cycle 3, `err_cnt`=1, `first_fail`=0, `din` stays 00.
- HOLD_CYCLES=3, `rst_n` pulsed low during vector 10:
  - All outputs go to zero immediately and no `done` pulse occurs.
  - A fresh start then completes with `done` at cycle 17 and `pass`=1.
- `start` held high for the whole run → exactly one run. A second run begins only when `start` is high in IDLE after DONE.

Source files
------------

// File: rtl/nand_gate_sequencer.sv
// Stimulus controller that walks a two-input gate through all four input vectors and scores dout
// against a truth table. Define NAND_SEQ_STOP_ON_FAIL_EN to end a run at its first mismatch.
module nand_gate_sequencer #(
   parameter int         HOLD_CYCLES = 1,
   parameter logic [3:0] EXPECT      = 4'b0111
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       dout,
   output logic       din_a,
   output logic       din_b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_cnt,
   output logic [1:0] first_fail,
   output logic [1:0] vec_idx
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [1:0]      vec_q, vec_d;
   logic [1:0]      din_q, din_d;
   logic [2:0]      err_q, err_d;
   logic [1:0]      ff_q, ff_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic            mismatch;
   logic            stop;
   logic [2:0]      err_next;

   // Run results are cleared on an accepted start so they stay readable in IDLE after a run.
   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      vec_d    = vec_q;
      din_d    = din_q;
      err_d    = err_q;
      ff_d     = ff_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      pass_d   = pass_q;
      mismatch = 1'b0;
      stop     = 1'b0;
      err_next = err_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_DRIVE;
               hold_d  = '0;
               vec_d   = 2'd0;
               din_d   = 2'b00;
               err_d   = 3'd0;
               ff_d    = 2'd0;
               pass_d  = 1'b0;
               busy_d  = 1'b1;
            end
         end
         ST_DRIVE: begin
            if (hold_q == HOLD_LAST) begin
               state_d = ST_SAMPLE;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         ST_SAMPLE: begin
            mismatch = (dout != EXPECT[vec_q]);
            err_next = err_q + {2'b00, mismatch};
            if (mismatch) begin
               err_d = err_next;
               if (err_q == 3'd0) begin
                  ff_d = vec_q;
               end
            end
`ifdef NAND_SEQ_STOP_ON_FAIL_EN
            stop = (vec_q == 2'd3) || mismatch;
`else
            stop = (vec_q == 2'd3);
`endif
            if (stop) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_next == 3'd0);
            end else begin
               state_d = ST_DRIVE;
               vec_d   = vec_q + 2'd1;
               din_d   = vec_q + 2'd1;
               hold_d  = '0;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
         vec_q   <= 2'd0;
         din_q   <= 2'b00;
         err_q   <= 3'd0;
         ff_q    <= 2'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         vec_q   <= vec_d;
         din_q   <= din_d;
         err_q   <= err_d;
         ff_q    <= ff_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   assign din_a      = din_q[1];
   assign din_b      = din_q[0];
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_cnt    = err_q;
   assign first_fail = ff_q;
   assign vec_idx    = vec_q;

endmodule

// File: tb/tb_nand_gate_sequencer.sv
// Scoreboard bench for nand_gate_sequencer: two instances (HOLD_CYCLES 1 and 3) drive a modelled gate.
module tb_nand_gate_sequencer;

   localparam logic [3:0] EXPECT_TT = 4'b0111;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstN1, start1, dout1, dinA1, dinB1, busy1, done1, pass1;
   logic [2:0] errCnt1;
   logic [1:0] firstFail1, vecIdx1;
   logic       rstN3, start3, dout3, dinA3, dinB3, busy3, done3, pass3;
   logic [2:0] errCnt3;
   logic [1:0] firstFail3, vecIdx3;

   int gateMode = 0;
   bit useH3 = 1'b0;
   int errors = 0;
   int checks = 0;

   // Gate under control: 0 = NAND, 1 = output stuck at 1, 2 = AND substituted
   function automatic logic gateModel(input int mode, input logic a, input logic b);
      case (mode)
         1:       return 1'b1;
         2:       return a & b;
         default: return ~(a & b);
      endcase
   endfunction

   assign dout1 = gateModel(gateMode, dinA1, dinB1);
   assign dout3 = gateModel(gateMode, dinA3, dinB3);

   nand_gate_sequencer #(.HOLD_CYCLES(1), .EXPECT(EXPECT_TT)) dut1 (
      .clk(clk), .rst_n(rstN1), .start(start1), .dout(dout1),
      .din_a(dinA1), .din_b(dinB1), .busy(busy1), .done(done1), .pass(pass1),
      .err_cnt(errCnt1), .first_fail(firstFail1), .vec_idx(vecIdx1)
   );

   nand_gate_sequencer #(.HOLD_CYCLES(3), .EXPECT(EXPECT_TT)) dut3 (
      .clk(clk), .rst_n(rstN3), .start(start3), .dout(dout3),
      .din_a(dinA3), .din_b(dinB3), .busy(busy3), .done(done3), .pass(pass3),
      .err_cnt(errCnt3), .first_fail(firstFail3), .vec_idx(vecIdx3)
   );

   logic [1:0] selDin, selFf, selVec;
   logic       selBusy, selDone, selPass;
   logic [2:0] selErr;
   assign selDin  = useH3 ? {dinA3, dinB3} : {dinA1, dinB1};
   assign selBusy = useH3 ? busy3 : busy1;
   assign selDone = useH3 ? done3 : done1;
   assign selPass = useH3 ? pass3 : pass1;
   assign selErr  = useH3 ? errCnt3 : errCnt1;
   assign selFf   = useH3 ? firstFail3 : firstFail1;
   assign selVec  = useH3 ? vecIdx3 : vecIdx1;

   typedef struct packed {
      logic [1:0] din;
      logic       busy;
      logic       done;
   } cycleExp_t;

   typedef struct {
      logic [2:0] err;
      logic [1:0] ff;
      logic       pass;
   } runExp_t;

   cycleExp_t cycleQ[$];
   runExp_t   runQ[$];

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic setStart(input logic v);
      if (useH3) start3 = v;
      else       start1 = v;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " din"},  {30'd0, selDin}, 32'd0);
      checkOutput({tag, " busy"}, {31'd0, selBusy}, 32'd0);
      checkOutput({tag, " done"}, {31'd0, selDone}, 32'd0);
      checkOutput({tag, " pass"}, {31'd0, selPass}, 32'd0);
      checkOutput({tag, " err"},  {29'd0, selErr}, 32'd0);
      checkOutput({tag, " ff"},   {30'd0, selFf}, 32'd0);
      checkOutput({tag, " vec"},  {30'd0, selVec}, 32'd0);
   endtask

   // Builds the expected per-cycle trace and run result, then drives one run and scores it
   task automatic applyStimulus(input int hold, input int mode, input bit holdStart, input int expDone);
      logic [2:0] err = 3'd0;
      logic [1:0] ff = 2'd0;
      logic [1:0] lastV = 2'd0;
      logic [1:0] vv;
      logic       act;
      bit         stopped = 1'b0;
      int         seenDone = 0;
      runExp_t    r;
      cycleExp_t  e;
      runExp_t    got;

      gateMode = mode;
      useH3    = (hold == 3);
      for (int v = 0; v < 4 && !stopped; v++) begin
         vv  = 2'(v);
         act = gateModel(mode, vv[1], vv[0]);
         for (int k = 0; k < hold + 1; k++) cycleQ.push_back('{din: vv, busy: 1'b1, done: 1'b0});
         if (act != EXPECT_TT[vv]) begin
            if (err == 3'd0) ff = vv;
            err = err + 3'd1;
`ifdef NAND_SEQ_STOP_ON_FAIL_EN
            stopped = 1'b1;
`endif
         end
         lastV = vv;
      end
      cycleQ.push_back('{din: lastV, busy: 1'b0, done: 1'b1});
      cycleQ.push_back('{din: lastV, busy: 1'b0, done: 1'b0});
      cycleQ.push_back('{din: lastV, busy: 1'b0, done: 1'b0});
      r.err  = err;
      r.ff   = ff;
      r.pass = (err == 3'd0);
      runQ.push_back(r);

      @(negedge clk);
      setStart(1'b1);
      @(posedge clk);
      #1;
      if (!holdStart) setStart(1'b0);
      for (int c = 1; cycleQ.size() > 0 && c < 200; c++) begin
         @(negedge clk);
         e = cycleQ.pop_front();
         checkOutput($sformatf("h%0d m%0d din c%0d", hold, mode, c),  {30'd0, selDin},  {30'd0, e.din});
         checkOutput($sformatf("h%0d m%0d vec c%0d", hold, mode, c),  {30'd0, selVec},  {30'd0, e.din});
         checkOutput($sformatf("h%0d m%0d busy c%0d", hold, mode, c), {31'd0, selBusy}, {31'd0, e.busy});
         checkOutput($sformatf("h%0d m%0d done c%0d", hold, mode, c), {31'd0, selDone}, {31'd0, e.done});
         if (selDone && seenDone == 0) seenDone = c;
         if (e.done) begin
            got = runQ.pop_front();
            checkOutput($sformatf("h%0d m%0d err_cnt", hold, mode), {29'd0, selErr}, {29'd0, got.err});
            checkOutput($sformatf("h%0d m%0d first_fail", hold, mode), {30'd0, selFf}, {30'd0, got.ff});
            checkOutput($sformatf("h%0d m%0d pass", hold, mode), {31'd0, selPass}, {31'd0, got.pass});
            setStart(1'b0);
         end
      end
      checkOutput($sformatf("h%0d m%0d done cycle", hold, mode), seenDone, expDone);
   endtask

   initial begin
      int andDone;
      rstN1 = 1'b0; rstN3 = 1'b0; start1 = 1'b0; start3 = 1'b0;
      #1;
      useH3 = 1'b0;
      checkAllZero("reset h1");
      useH3 = 1'b1;
      checkAllZero("reset h3");
      repeat (2) @(negedge clk);
      rstN1 = 1'b1; rstN3 = 1'b1;
      repeat (2) @(negedge clk);

      applyStimulus(1, 0, 1'b0, 9);
      applyStimulus(1, 1, 1'b0, 9);
`ifdef NAND_SEQ_STOP_ON_FAIL_EN
      andDone = 3;
`else
      andDone = 9;
`endif
      applyStimulus(1, 2, 1'b0, andDone);
      applyStimulus(1, 0, 1'b1, 9);

      // Abort a HOLD_CYCLES=3 run while vector 10 is driven
      useH3 = 1'b1;
      gateMode = 0;
      @(negedge clk);
      start3 = 1'b1;
      @(posedge clk);
      #1;
      start3 = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("abort pre din", {30'd0, selDin}, 32'd2);
      checkOutput("abort pre busy", {31'd0, selBusy}, 32'd1);
      rstN3 = 1'b0;
      #1;
      checkAllZero("abort");
      @(negedge clk);
      rstN3 = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checkOutput($sformatf("post abort done c%0d", c), {31'd0, selDone}, 32'd0);
         checkOutput($sformatf("post abort busy c%0d", c), {31'd0, selBusy}, 32'd0);
      end
      applyStimulus(3, 0, 1'b0, 17);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
